vga_sync_gen: RTL

Generates the 640x480 VGA timing the game datapath consumes: free-running column/row counters, porch-correct active-low HSync/VSync pulses, an active-video flag, and frame strobes. It also re-aligns the renderer's RGB with the syncs. It sits between the top-level pins and the rendering logic. It is the transmit end of the sync interface that Sync_To_Count receives, and replaces the external sync source so the board drives the monitor directly.

---
 rtl/vga_timing_pkg.sv | 58 +++++
 rtl/sync_delay_line.sv | 44 ++++
 rtl/vga_sync_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants, phase encodings and the sync bundle
// that travels through the sync/blanking delay line.
package vga_timing_pkg;

    // Counter widths
    localparam int CNT_W    = 10;
    localparam int FRAME_W  = 8;
    localparam int COLOUR_W = 4;

    // Horizontal timing (pixel clocks)
    localparam int TOTAL_COLS    = 800;
    localparam int ACTIVE_COLS   = 640;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int H_BACK_PORCH  = 48;

    // Vertical timing (lines)
    localparam int TOTAL_ROWS    = 525;
    localparam int ACTIVE_ROWS   = 480;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;
    localparam int V_BACK_PORCH  = 33;

    // Renderer latency that the syncs and blanking are re-aligned to
    localparam int VIDEO_DELAY = 2;

    typedef enum logic [1:0] {
        H_ACTIVE = 2'b00,
        H_FRONT  = 2'b01,
        H_SYNC   = 2'b10,
        H_BACK   = 2'b11
    } h_phase_e;

    typedef enum logic [1:0] {
        V_ACTIVE = 2'b00,
        V_FRONT  = 2'b01,
        V_SYNC   = 2'b10,
        V_BACK   = 2'b11
    } v_phase_e;

    // Signals that must stay aligned with the renderer's colour
    typedef struct packed {
        logic hsync;   // active low
        logic vsync;   // active low
        logic active;  // visible pixel
    } sync_bus_t;

    localparam int SYNC_BUS_W = $bits(sync_bus_t);

    // Level of the bundle while nothing is being displayed or synced
    localparam sync_bus_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

    // Truncate an elaboration-time integer to counter width
    function automatic logic [CNT_W-1:0] to_cnt(input int value);
        return value[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a synchronous reset to a chosen vector.
// A depth of zero turns it into a plain wire.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0] o_Data
);

    if (DEPTH == 0) begin : g_bypass
        // Clock and reset have no job when the line is bypassed
        logic unused_bypass;
        assign unused_bypass = i_Clk ^ i_Reset;

        // Zero latency: the raw value passes straight through
        assign o_Data = i_Data;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift one stage per clock; reset loads every stage with the idle vector
        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                // NOTE: these stages are individual flops rather than a RAM, so
                // resetting every entry is cheap and keeps a reset from letting a
                // half-finished sync pulse drain out of the line.
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RESET_VAL;
                end
            end else begin
                stage_q[0] <= i_Data;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign o_Data = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480 VGA timing generator: free-running column/row/frame counters,
// horizontal and vertical phase FSMs, and active-low syncs plus blanked
// colour delayed to line up with the renderer's pipeline.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int c_TOTAL_COLS    = TOTAL_COLS,
    parameter int c_TOTAL_ROWS    = TOTAL_ROWS,
    parameter int c_ACTIVE_COLS   = ACTIVE_COLS,
    parameter int c_ACTIVE_ROWS   = ACTIVE_ROWS,
    parameter int c_H_FRONT_PORCH = H_FRONT_PORCH,
    parameter int c_H_SYNC        = H_SYNC_WIDTH,
    parameter int c_H_BACK_PORCH  = H_BACK_PORCH,
    parameter int c_V_FRONT_PORCH = V_FRONT_PORCH,
    parameter int c_V_SYNC        = V_SYNC_WIDTH,
    parameter int c_V_BACK_PORCH  = V_BACK_PORCH,
    parameter int c_VIDEO_DELAY   = VIDEO_DELAY
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic [COLOUR_W-1:0] i_Red_Video,
    input  logic [COLOUR_W-1:0] i_Grn_Video,
    input  logic [COLOUR_W-1:0] i_Blu_Video,
    output logic [CNT_W-1:0]    o_Col_Count,
    output logic [CNT_W-1:0]    o_Row_Count,
    output logic                o_Active,
    output logic                o_Frame_Start,
    output logic [FRAME_W-1:0]  o_Frame_Count,
    output logic                o_HSync,
    output logic                o_VSync,
    output logic [COLOUR_W-1:0] o_Red_Video,
    output logic [COLOUR_W-1:0] o_Grn_Video,
    output logic [COLOUR_W-1:0] o_Blu_Video
);

    // Last column / row of each phase, derived from the timing parameters
    localparam logic [CNT_W-1:0] COL_LAST      = to_cnt(c_TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] H_ACTIVE_LAST = to_cnt(c_ACTIVE_COLS - 1);
    localparam logic [CNT_W-1:0] H_FRONT_LAST  = to_cnt(c_ACTIVE_COLS + c_H_FRONT_PORCH - 1);
    localparam logic [CNT_W-1:0] H_SYNC_LAST   = to_cnt(c_ACTIVE_COLS + c_H_FRONT_PORCH
                                                        + c_H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_BACK_LAST   = to_cnt(c_ACTIVE_COLS + c_H_FRONT_PORCH
                                                        + c_H_SYNC + c_H_BACK_PORCH - 1);

    localparam logic [CNT_W-1:0] ROW_LAST      = to_cnt(c_TOTAL_ROWS - 1);
    localparam logic [CNT_W-1:0] V_ACTIVE_LAST = to_cnt(c_ACTIVE_ROWS - 1);
    localparam logic [CNT_W-1:0] V_FRONT_LAST  = to_cnt(c_ACTIVE_ROWS + c_V_FRONT_PORCH - 1);
    localparam logic [CNT_W-1:0] V_SYNC_LAST   = to_cnt(c_ACTIVE_ROWS + c_V_FRONT_PORCH
                                                        + c_V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_BACK_LAST   = to_cnt(c_ACTIVE_ROWS + c_V_FRONT_PORCH
                                                        + c_V_SYNC + c_V_BACK_PORCH - 1);

    logic [CNT_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    h_phase_e           h_phase_q;
    v_phase_e           v_phase_q;
    sync_bus_t          raw_sync;
    sync_bus_t          dly_sync;

    // Counter next-state: column wraps into a row step, row wrap bumps the frame
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        col_d   = col_q + to_cnt(1);
        row_d   = row_q;
        frame_d = frame_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
                row_d   = '0;
                frame_d = frame_q + FRAME_W'(1);
            end else begin
                row_d = row_q + to_cnt(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge i_Clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples its inputs from before the edge, regardless of order.
        if (i_Reset) begin
            col_q   <= '0;
            row_q   <= '0;
            frame_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end

    // Phase FSMs: horizontal steps on column compares, vertical only on line wrap
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            h_phase_q <= H_ACTIVE;
            v_phase_q <= V_ACTIVE;
        end else begin
            case (h_phase_q)
                H_ACTIVE: if (col_q == H_ACTIVE_LAST) h_phase_q <= H_FRONT;
                H_FRONT:  if (col_q == H_FRONT_LAST)  h_phase_q <= H_SYNC;
                H_SYNC:   if (col_q == H_SYNC_LAST)   h_phase_q <= H_BACK;
                H_BACK:   if (col_q == H_BACK_LAST)   h_phase_q <= H_ACTIVE;
                default:                              h_phase_q <= H_ACTIVE;
            endcase

            if (col_q == COL_LAST) begin
                case (v_phase_q)
                    V_ACTIVE: if (row_q == V_ACTIVE_LAST) v_phase_q <= V_FRONT;
                    V_FRONT:  if (row_q == V_FRONT_LAST)  v_phase_q <= V_SYNC;
                    V_SYNC:   if (row_q == V_SYNC_LAST)   v_phase_q <= V_BACK;
                    V_BACK:   if (row_q == V_BACK_LAST)   v_phase_q <= V_ACTIVE;
                    default:                              v_phase_q <= V_ACTIVE;
                endcase
            end
        end
    end

    // Undelayed sync and visibility levels decoded from the phases
    always_comb begin
        raw_sync        = SYNC_IDLE;
        raw_sync.hsync  = (h_phase_q != H_SYNC);
        raw_sync.vsync  = (v_phase_q != V_SYNC);
        raw_sync.active = (h_phase_q == H_ACTIVE) && (v_phase_q == V_ACTIVE);
    end

    // Delay the syncs and blanking so they meet the renderer's colour
    sync_delay_line #(
        .WIDTH     (SYNC_BUS_W),
        .DEPTH     (c_VIDEO_DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Data  (raw_sync),
        .o_Data  (dly_sync)
    );

    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Frame_Count = frame_q;
    assign o_Active      = raw_sync.active;
    assign o_Frame_Start = (col_q == '0) && (row_q == '0);

    assign o_HSync       = dly_sync.hsync;
    assign o_VSync       = dly_sync.vsync;

    // Colour is passed through only while the delayed pixel is visible
    assign o_Red_Video   = dly_sync.active ? i_Red_Video : '0;
    assign o_Grn_Video   = dly_sync.active ? i_Grn_Video : '0;
    assign o_Blu_Video   = dly_sync.active ? i_Blu_Video : '0;

endmodule
